// File: rtl/nibble_rotate_sched.sv
// Round-robin scheduler for two requesters sharing one nibble-rotate unit.
// A granted word is walked through the unit one nibble per cycle, then returned with its requester ID.
`timescale 1ns/1ps

module nibble_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       wr,
  input  logic [3:0] wr_val,
  output logic [3:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (ld) q <= ld_val;
    else if (wr) q <= wr_val;
endmodule

module nibble_rotate_sched (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid_in,
  output logic [1:0]      req_ready_out,
  input  logic [1:0][31:0] req_data_in,
  input  logic [1:0][1:0] req_amt_in,
  input  logic [1:0][7:0] req_mask_in,
  output logic [31:0]     shf_data_out,
  output logic [4:0]      shf_amt_out,
  input  logic [31:0]     shf_result_in,
  output logic            res_valid_out,
  input  logic            res_ready_in,
  output logic [31:0]     res_data_out,
  output logic            res_id_out,
  output logic            busy_out
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [1:0] amt;
    logic [7:0] mask;
    logic       id;
  } job_t;

  state_t state, state_nxt;
  job_t   job;
  logic   ptr;
  logic [2:0] idx;
  logic [1:0] grant;
  logic       accept, sel;
  logic [NUM_LANES-1:0][VEC_W-1:0] work;
  logic [2*NUM_LANES*VEC_W-1:0]    work_dbl;
  logic       unused_hi;

  // Only the low nibble of the rotator result is meaningful.
  assign unused_hi = ^shf_result_in[31:4];

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      unique case (req_valid_in)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign accept        = |grant;
  assign sel           = grant[1];
  assign req_ready_out = grant;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = RUN;
      RUN:     if (idx == 3'd7)  state_nxt = DONE;
      DONE:    if (res_ready_in) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      idx   <= '0;
      job   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        job <= '{amt: req_amt_in[sel], mask: req_mask_in[sel], id: sel};
        ptr <= ~sel;
        idx <= '0;
      end else if (state == RUN) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Each lane owns one nibble of the work word; it is rewritten only on its own RUN cycle.
  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      nibble_lane u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (accept),
        .ld_val (req_data_in[sel][VEC_W*k +: VEC_W]),
        .wr     (state == RUN && idx == 3'(k)),
        .wr_val (shf_result_in[VEC_W-1:0]),
        .q      (work[k])
      );
    end
  endgenerate

  // Doubling the word turns the rotate-right by 4*idx into a plain part-select.
  assign work_dbl     = {work, work};
  assign shf_data_out = (state == RUN) ? work_dbl[{idx, 2'b00} +: 32] : 32'd0;
  assign shf_amt_out  = (state == RUN && job.mask[idx]) ? {3'b000, job.amt} : 5'd0;

  assign res_valid_out = (state == DONE);
  assign res_data_out  = (state == DONE) ? work : 32'd0;
  assign res_id_out    = (state == DONE) & job.id;
  assign busy_out      = (state != IDLE);
endmodule

// File: tb/tb_nibble_rotate_sched.sv
// Scoreboard bench for nibble_rotate_sched: per-requester drivers, a behavioural rotator,
// and a negedge monitor that compares RUN activity and results against a nibble-level model.
`timescale 1ns/1ps

module tb_nibble_rotate_sched;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid_in, req_ready_out;
  logic [1:0][31:0] req_data_in;
  logic [1:0][1:0]  req_amt_in;
  logic [1:0][7:0]  req_mask_in;
  logic [31:0]      shf_data_out, shf_result_in, res_data_out;
  logic [4:0]       shf_amt_out;
  logic             res_valid_out, res_ready_in, res_id_out, busy_out;

  typedef struct packed { logic [31:0] data; logic [1:0] amt; logic [7:0] mask; } req_t;
  typedef struct packed { logic [31:0] data; logic id; int cyc; } exp_t;

  req_t   q0[$], q1[$];
  exp_t   exp_q[$];
  int     gnt_log[$];
  logic [31:0] res_log[$];
  req_t   r0, r1, cur;
  logic   v0, v1;
  int     n_chk = 0, n_fail = 0, cyc = 0, run_idx = 8;
  bit     stalled = 0, rnd_rdy = 0, rdy_force = 1;
  logic [3:0] rot_nib;

  assign req_valid_in = {v1, v0};
  assign req_data_in  = {r1.data, r0.data};
  assign req_amt_in   = {r1.amt, r0.amt};
  assign req_mask_in  = {r1.mask, r0.mask};

  nibble_rotate_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_data_in(req_data_in), .req_amt_in(req_amt_in), .req_mask_in(req_mask_in),
    .shf_data_out(shf_data_out), .shf_amt_out(shf_amt_out), .shf_result_in(shf_result_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .res_data_out(res_data_out), .res_id_out(res_id_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared rotate unit: rotates only bits [3:0]; upper bits are deliberately garbage.
  always_comb begin
    rot_nib = shf_data_out[3:0];
    case (shf_amt_out)
      5'd1: rot_nib = {shf_data_out[0], shf_data_out[3:1]};
      5'd2: rot_nib = {shf_data_out[1:0], shf_data_out[3:2]};
      5'd3: rot_nib = {shf_data_out[2:0], shf_data_out[3]};
      default: rot_nib = shf_data_out[3:0];
    endcase
    shf_result_in = {~shf_data_out[31:4], rot_nib};
  end

  // Amount 3 (left by one) is the same as right by three on a 4-bit value.
  function automatic logic [3:0] nib_ref(input logic [3:0] n, input logic [1:0] a);
    int v, r;
    v = int'(n);
    r = int'(a);
    return 4'(((v >> r) | (v << (4 - r))) & 15);
  endfunction

  // Word after the first 'upto' nibbles have had their turn.
  function automatic logic [31:0] ref_word(input logic [31:0] d, input logic [1:0] a,
                                           input logic [7:0] m, input int upto);
    logic [31:0] w;
    w = d;
    for (int k = 0; k < upto; k++)
      if (m[k]) w[4*k +: 4] = nib_ref(d[4*k +: 4], a);
    return w;
  endfunction

  function automatic logic [31:0] rotr_nib(input logic [31:0] w, input int n);
    logic [31:0] o;
    for (int j = 0; j < 8; j++) o[4*j +: 4] = w[4*((j + n) % 8) +: 4];
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_out), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid_out), 32'd0);
    chk({tag, "_res_data"}, res_data_out, 32'd0);
    chk({tag, "_res_id"}, 32'(res_id_out), 32'd0);
    chk({tag, "_shf_data"}, shf_data_out, 32'd0);
    chk({tag, "_shf_amt"}, 32'(shf_amt_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy_out), 32'd0);
  endtask

  // Requester drivers: each owns its own valid/payload and holds them until granted.
  initial begin
    v0 = 1'b0; r0 = '0;
    forever begin
      @(posedge clk); #1;
      if (q0.size() > 0) begin
        r0 = q0.pop_front(); v0 = 1'b1;
        @(negedge clk);
        while (!(req_ready_out[0] && rst_n)) @(negedge clk);
        @(posedge clk); #1; v0 = 1'b0;
      end
    end
  end

  initial begin
    v1 = 1'b0; r1 = '0;
    forever begin
      @(posedge clk); #1;
      if (q1.size() > 0) begin
        r1 = q1.pop_front(); v1 = 1'b1;
        @(negedge clk);
        while (!(req_ready_out[1] && rst_n)) @(negedge clk);
        @(posedge clk); #1; v1 = 1'b0;
      end
    end
  end

  initial begin
    res_ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready_in = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: RUN-cycle rotator traffic, grants, and result scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_idx = 8;
      exp_q.delete();
    end else begin
      if (run_idx < 8) begin
        chk("shf_amt", 32'(shf_amt_out), cur.mask[run_idx] ? 32'(cur.amt) : 32'd0);
        chk("shf_data", shf_data_out,
            rotr_nib(ref_word(cur.data, cur.amt, cur.mask, run_idx), run_idx));
        run_idx++;
      end else begin
        chk("shf_data_idle", shf_data_out, 32'd0);
        chk("shf_amt_idle", 32'(shf_amt_out), 32'd0);
      end
      chk("ready_onehot", 32'(req_ready_out == 2'b11), 32'd0);
      for (int r = 0; r < 2; r++) begin
        if (req_valid_in[r] && req_ready_out[r]) begin
          cur = '{data: req_data_in[r], amt: req_amt_in[r], mask: req_mask_in[r]};
          exp_q.push_back('{data: ref_word(cur.data, cur.amt, cur.mask, 8), id: 1'(r), cyc: cyc});
          gnt_log.push_back(r);
          run_idx = 0;
          stalled = 0;
        end
      end
      if (res_valid_out) begin
        if (!res_ready_in) stalled = 1;
        else if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result at %0t: got %h with no job outstanding", $time, res_data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_data", res_data_out, e.data);
          chk("res_id", 32'(res_id_out), 32'(e.id));
          if (!stalled) chk("latency", 32'(cyc - e.cyc), 32'd9);
          res_log.push_back(res_data_out);
        end
      end
    end
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || v0 || v1 || exp_q.size() > 0 || busy_out) && n < bound) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_t rq;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #3; rst_n = 1'b1;

    // Both requesters valid from reset: grants 0,1,0,1 with the directed test-plan words.
    gnt_log.delete(); res_log.delete();
    q0.push_back('{data: 32'h12345678, amt: 2'd1, mask: 8'h01});
    q0.push_back('{data: 32'h12345678, amt: 2'd2, mask: 8'h0F});
    q1.push_back('{data: 32'h12345678, amt: 2'd1, mask: 8'hFF});
    q1.push_back('{data: 32'h00000008, amt: 2'd3, mask: 8'h01});
    wait_idle(200);
    chk("gnt_count", 32'(gnt_log.size()), 32'd4);
    chk("res_count", 32'(res_log.size()), 32'd4);
    if (gnt_log.size() == 4 && res_log.size() == 4) begin
      chk("gnt0", 32'(gnt_log[0]), 32'd0);
      chk("gnt1", 32'(gnt_log[1]), 32'd1);
      chk("gnt2", 32'(gnt_log[2]), 32'd0);
      chk("gnt3", 32'(gnt_log[3]), 32'd1);
      chk("plan_mask01", res_log[0], 32'h12345674);
      chk("plan_maskFF", res_log[1], 32'h8192A3B4);
      chk("plan_amt2", res_log[2], 32'h123459D2);
      chk("plan_amt3", res_log[3], 32'h00000001);
    end

    // Empty mask and zero amount leave the word unchanged.
    res_log.delete();
    q0.push_back('{data: 32'hDEADBEEF, amt: 2'd2, mask: 8'h00});
    wait_idle(100);
    q1.push_back('{data: 32'hCAFEF00D, amt: 2'd0, mask: 8'hFF});
    wait_idle(100);
    chk("unchanged_count", 32'(res_log.size()), 32'd2);
    if (res_log.size() == 2) begin
      chk("mask00_unchanged", res_log[0], 32'hDEADBEEF);
      chk("amt0_unchanged", res_log[1], 32'hCAFEF00D);
    end

    // Backpressure: DONE holds, a competing request sees ready=0, then is granted after release.
    rdy_force = 0;
    repeat (2) @(negedge clk);
    q0.push_back('{data: 32'h0F0F0F0F, amt: 2'd3, mask: 8'hAA});
    n = 0;
    @(negedge clk);
    while (!res_valid_out && n < 30) begin @(negedge clk); n++; end
    chk("bp_reached_done", 32'(res_valid_out), 32'd1);
    q1.push_back('{data: 32'h11111111, amt: 2'd1, mask: 8'hFF});
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid_out), 32'd1);
      chk("bp_data", res_data_out, ref_word(32'h0F0F0F0F, 2'd3, 8'hAA, 8));
      chk("bp_id", 32'(res_id_out), 32'd0);
      chk("bp_busy", 32'(busy_out), 32'd1);
      chk("bp_no_grant", 32'(req_ready_out), 32'd0);
    end
    rdy_force = 1;
    @(posedge clk); #2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_after", 32'(busy_out), 32'd0);
    chk("bp_next_grant", 32'(req_ready_out), 32'b10);
    wait_idle(100);

    // Randomized traffic with random result backpressure.
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      rq = '{data: $urandom, amt: 2'($urandom_range(0, 3)), mask: 8'($urandom)};
      if ($urandom_range(0, 1) == 0) q0.push_back(rq); else q1.push_back(rq);
    end
    wait_idle(3000);
    rnd_rdy = 0; rdy_force = 1;
    repeat (2) @(negedge clk);

    // Reset in the idx-4 cycle of a job aborts it silently.
    q0.push_back('{data: 32'h89ABCDEF, amt: 2'd1, mask: 8'hFF});
    n = 0;
    do begin @(negedge clk); #1; n++; end while (run_idx != 4 && n < 50);
    chk("abort_reached_idx4", 32'(run_idx), 32'd4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    @(posedge clk); #3; rst_n = 1'b1;
    @(negedge clk); #1;
    chk("abort_idle_after", 32'(busy_out), 32'd0);
    res_log.delete();
    q1.push_back('{data: 32'h12345678, amt: 2'd1, mask: 8'hFF});
    wait_idle(100);
    repeat (3) @(negedge clk);
    chk("after_abort_count", 32'(res_log.size()), 32'd1);
    if (res_log.size() == 1) chk("after_abort_data", res_log[0], 32'h8192A3B4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
